// File: rtl/alu_arbiter_if.sv
// Request, shared-ALU and response signals of the two-requester ALU arbiter.
// The arbiter connects through the slave modport; its environment uses master.
interface alu_arbiter_if #(
    parameter int DATA_W = 4,
    parameter int RES_W  = 8
);
    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic [2:0]        req0_op;

    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;
    logic [2:0]        req1_op;

    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [2:0]        alu_sel;
    logic [RES_W-1:0]  alu_result;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [RES_W-1:0]  rsp_data;
    logic              rsp_id;

    logic              busy;
    logic [7:0]        op_count;

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req1_ready,
        input  alu_a, alu_b, alu_sel,
        output alu_result,
        input  rsp_valid, rsp_data, rsp_id,
        output rsp_ready,
        input  busy, op_count
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req1_ready,
        output alu_a, alu_b, alu_sel,
        input  alu_result,
        output rsp_valid, rsp_data, rsp_id,
        input  rsp_ready,
        output busy, op_count
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters:
// accept -> issue (capture result) -> hold response until consumed.
module alu_arbiter #(
    parameter int DATA_W = 4,
    parameter int RES_W  = 8
) (
    input logic          clk,
    input logic          rst,
    alu_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [2:0]        op_q;
    logic              gid_q;
    logic              last_grant;

    logic [RES_W-1:0]  rsp_data_q;
    logic              rsp_id_q;
    logic              rsp_valid_q;
    logic [7:0]        op_count_q;

    logic              grant;
    logic              idle_open;
    logic              accept;
    logic              rsp_fire;

    // A lone requester always wins; on a tie the one not served last wins.
    always_comb begin
        if (bus.req0_valid && bus.req1_valid) begin
            grant = ~last_grant;
        end else begin
            grant = bus.req1_valid;
        end
    end

    assign idle_open      = (state == IDLE) && !rst;
    assign bus.req0_ready = idle_open && bus.req0_valid && !grant;
    assign bus.req1_ready = idle_open && bus.req1_valid && grant;
    assign accept         = bus.req0_ready || bus.req1_ready;
    assign rsp_fire       = (state == RESP) && bus.rsp_ready;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = ISSUE;
            ISSUE:   state_next = RESP;
            RESP:    if (bus.rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            gid_q       <= 1'b0;
            last_grant  <= 1'b1;
            rsp_data_q  <= '0;
            rsp_id_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            op_count_q  <= '0;
        end else begin
            if (accept) begin
                a_q   <= grant ? bus.req1_a  : bus.req0_a;
                b_q   <= grant ? bus.req1_b  : bus.req0_b;
                op_q  <= grant ? bus.req1_op : bus.req0_op;
                gid_q <= grant;
            end
            if (state == ISSUE) begin
                rsp_data_q  <= bus.alu_result;
                rsp_id_q    <= gid_q;
                rsp_valid_q <= 1'b1;
            end
            if (rsp_fire) begin
                rsp_valid_q <= 1'b0;
                op_count_q  <= op_count_q + 8'd1;
                last_grant  <= rsp_id_q;
            end
        end
    end

    // ALU operands come only from the latched copy; forced to zero while in reset.
    assign bus.alu_a    = rst ? '0 : a_q;
    assign bus.alu_b    = rst ? '0 : b_q;
    assign bus.alu_sel  = rst ? '0 : op_q;

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.busy      = (state != IDLE);
    assign bus.op_count  = op_count_q;

    a_ready_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(bus.req0_ready && bus.req1_ready));

    a_rsp_held: assert property (@(posedge clk) disable iff (rst)
        (state == RESP && !bus.rsp_ready) |=>
            (bus.rsp_valid && $stable(bus.rsp_data) && $stable(bus.rsp_id)));

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: expected results queued at accept,
// compared at each response handshake, with a cycle model of the handshake.
module tb_alu_arbiter;

    localparam int DATA_W = 4;
    localparam int RES_W  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_arbiter_if #(.DATA_W(DATA_W), .RES_W(RES_W)) bus ();

    alu_arbiter #(.DATA_W(DATA_W), .RES_W(RES_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          done_cnt = 0;
    int          cyc      = 0;

    logic [10:0] p0[$];
    logic [10:0] p1[$];
    logic [8:0]  exp_q[$];
    logic        id_log[$];

    int          m_phase = 0;
    logic        m_last  = 1'b1;
    logic [7:0]  m_count = '0;
    logic [10:0] m_lat   = '0;

    function automatic logic [7:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                          input logic [2:0] op);
        logic [7:0] ea;
        logic [7:0] eb;
        ea = {4'b0, a};
        eb = {4'b0, b};
        case (op)
            3'd0:    return ea + eb;
            3'd1:    return ea - eb;
            3'd2:    return ea & eb;
            3'd3:    return ea | eb;
            3'd4:    return ea ^ eb;
            3'd5:    return ea << b[1:0];
            3'd6:    return ea * eb;
            default: return (b == 4'd0) ? 8'd0 : ea / eb;
        endcase
    endfunction

    assign bus.alu_result = alu_fn(bus.alu_a, bus.alu_b, bus.alu_sel);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_done(input int target, input int budget);
        int i = 0;
        while (done_cnt < target && i < budget) begin
            @(negedge clk);
            i++;
        end
        check("handshake_timeout", done_cnt >= target, 1);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Requester drivers: present the front of each pending queue until accepted.
    initial begin
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        {bus.req0_a, bus.req0_b, bus.req0_op} = '0;
        {bus.req1_a, bus.req1_b, bus.req1_op} = '0;
        forever begin
            @(posedge clk);
            #1;
            if (p0.size() != 0) begin
                bus.req0_valid = 1'b1;
                {bus.req0_a, bus.req0_b, bus.req0_op} = p0[0];
            end else begin
                bus.req0_valid = 1'b0;
                {bus.req0_a, bus.req0_b, bus.req0_op} = 11'($urandom);
            end
            if (p1.size() != 0) begin
                bus.req1_valid = 1'b1;
                {bus.req1_a, bus.req1_b, bus.req1_op} = p1[0];
            end else begin
                bus.req1_valid = 1'b0;
                {bus.req1_a, bus.req1_b, bus.req1_op} = 11'($urandom);
            end
        end
    end

    // Monitor and scoreboard, sampled away from the active edge.
    always @(negedge clk) begin : mon
        logic        g;
        logic [1:0]  exp_rdy;
        logic [10:0] op;
        if (rst) begin
            check("rst_ready", {bus.req1_ready, bus.req0_ready}, 2'b00);
            check("rst_alu", {bus.alu_a, bus.alu_b, bus.alu_sel}, 11'd0);
            m_phase = 0;
            m_last  = 1'b1;
            m_count = '0;
            m_lat   = '0;
            exp_q.delete();
        end else begin
            g       = 1'b0;
            exp_rdy = 2'b00;
            if (m_phase == 0 && (bus.req0_valid || bus.req1_valid)) begin
                g       = (bus.req0_valid && bus.req1_valid) ? ~m_last : bus.req1_valid;
                exp_rdy = g ? 2'b10 : 2'b01;
            end
            check("ready", {bus.req1_ready, bus.req0_ready}, exp_rdy);
            check("busy", bus.busy, m_phase != 0);
            check("rsp_valid", bus.rsp_valid, m_phase == 2);
            check("op_count", bus.op_count, m_count);
            check("alu_ops", {bus.alu_a, bus.alu_b, bus.alu_sel}, m_lat);
            if (m_phase == 0) begin
                if (exp_rdy != 2'b00) begin
                    op = g ? {bus.req1_a, bus.req1_b, bus.req1_op}
                           : {bus.req0_a, bus.req0_b, bus.req0_op};
                    m_lat = op;
                    exp_q.push_back({g, alu_fn(op[10:7], op[6:3], op[2:0])});
                    if (g && p1.size() != 0) void'(p1.pop_front());
                    if (!g && p0.size() != 0) void'(p0.pop_front());
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                m_phase = 2;
            end else begin
                if (exp_q.size() == 0) begin
                    check("rsp_expected", exp_q.size(), 1);
                end else begin
                    check("rsp_data", bus.rsp_data, exp_q[0][7:0]);
                    check("rsp_id", bus.rsp_id, exp_q[0][8]);
                    if (bus.rsp_ready) begin
                        m_last = exp_q[0][8];
                        id_log.push_back(bus.rsp_id);
                        void'(exp_q.pop_front());
                        m_count = m_count + 8'd1;
                        done_cnt++;
                        m_phase = 0;
                    end
                end
            end
        end
    end

    initial begin : main
        int t0;
        int t1;
        int hold;
        int base;
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #2;

        // Tie straight after reset: requester 0 first, then 1 (divide by zero).
        id_log.delete();
        p0.push_back({4'hF, 4'hF, 3'b110});
        p1.push_back({4'h9, 4'h0, 3'b111});
        wait_done(2, 40);
        check("tie_count", id_log.size(), 2);
        if (id_log.size() == 2) check("tie_order", {id_log[0], id_log[1]}, 2'b01);

        // Single add with latency measurement.
        @(posedge clk);
        #2;
        t0 = 0;
        t1 = -100;
        p0.push_back({4'd3, 4'd5, 3'b000});
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.req0_ready) begin
                t0 = cyc;
                break;
            end
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                t1 = cyc;
                break;
            end
        end
        check("latency", t1 - t0, 2);
        wait_done(3, 20);
        @(negedge clk);
        check("op_count_add", bus.op_count, 3);

        // Backpressure on requester 1 for five cycles.
        @(posedge clk);
        #2;
        bus.rsp_ready = 1'b0;
        p1.push_back({4'd6, 4'd3, 3'b001});
        hold = 0;
        for (int i = 0; i < 20 && !bus.rsp_valid; i++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            hold += int'(bus.rsp_valid);
        end
        check("bp_hold", hold, 5);
        @(posedge clk);
        #1 bus.rsp_ready = 1'b1;
        wait_done(4, 20);

        // Fairness with both requesters continuously valid.
        @(posedge clk);
        #2;
        id_log.delete();
        for (int i = 0; i < 3; i++) begin
            p0.push_back(11'($urandom));
            p1.push_back(11'($urandom));
        end
        wait_done(10, 60);
        check("fair_count", id_log.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < id_log.size()) check("fair_order", id_log[i], i % 2);
        end

        // Fill up to 256 handshakes so op_count wraps to zero.
        @(posedge clk);
        #2;
        for (int i = 10; i < 256; i++) begin
            if ($urandom_range(0, 1) == 1) p0.push_back(11'($urandom));
            else p1.push_back(11'($urandom));
        end
        wait_done(256, 2000);
        @(negedge clk);
        check("op_count_wrap", bus.op_count, 0);
        check("wrap_busy", bus.busy, 0);

        // Reset while a response is being held.
        @(posedge clk);
        #2;
        bus.rsp_ready = 1'b0;
        p0.push_back({4'd12, 4'd3, 3'b100});
        for (int i = 0; i < 20 && !bus.rsp_valid; i++) @(negedge clk);
        check("mid_rsp_seen", bus.rsp_valid, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", bus.rsp_valid, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_count", bus.op_count, 0);
        @(posedge clk);
        #1 bus.rsp_ready = 1'b1;
        base = done_cnt;
        id_log.delete();
        p1.push_back({4'd7, 4'd2, 3'b010});
        wait_done(base + 1, 20);
        @(negedge clk);
        check("post_rst_count", bus.op_count, 1);
        check("post_rst_id_log", id_log.size(), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
